branch_unit: RTL and testbench

Parametrised program-counter sequencer, successor to the fixed 4-flag/16-bit brancher. Accepts one control-flow operation per handshake: increment, unconditional jump, or conditional branch on a flag mask in ANY/ALL/NONE mode. It also supports call/return through an internal return-address stack. It sits between the decode stage (which supplies op, target and mask) and the fetch stage (which consumes `tx_pc`).

---
 rtl/branch_unit_pkg.sv | 17 +
 rtl/branch_unit_stack.sv | 33 +++
 rtl/branch_unit.sv | 82 ++++++++
 tb/tb_branch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_unit_pkg.sv
// branch_unit_pkg: opcodes, FSM states and branch-condition evaluation shared by the branch unit
package branch_unit_pkg;
  localparam int COND_W = 64;
  typedef enum logic [2:0] {
    OP_NEXT, OP_JUMP, OP_BR_ANY, OP_BR_ALL, OP_BR_NONE, OP_CALL, OP_RET, OP_RSVD
  } op_t;
  typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;
  // Callers zero-extend FLAG_W-wide flags/mask; padding bits never affect the result.
  function automatic logic cond_eval(op_t op, logic [COND_W-1:0] flags, logic [COND_W-1:0] mask);
    logic [COND_W-1:0] hit;
    hit = flags & mask;
    return op == OP_JUMP ? 1'b1 :
           op == OP_BR_ANY ? |hit :
           op == OP_BR_ALL ? hit == mask :
           op == OP_BR_NONE ? ~|hit : 1'b0;
  endfunction
endpackage

// File: rtl/branch_unit_stack.sv
// branch_stack: return-address LIFO kept as a shift register with the top entry at index 0
module branch_stack #(
  parameter int PC_W = 16,
  parameter int STACK_DEPTH = 4,
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               push,
  input  logic               pop,
  input  logic [PC_W-1:0]    push_data,
  output logic [PC_W-1:0]    top,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_W-1:0] depth
);
  logic [PC_W-1:0] mem [STACK_DEPTH];
  assign full = depth == DEPTH_W'(STACK_DEPTH);
  assign empty = depth == '0;
  assign top = mem[0];
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      depth <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[0] <= push_data;
      for (int i = 1; i < STACK_DEPTH; i++) mem[i] <= mem[i-1];
      depth <= depth + 1'b1;
    end else if (pop && !empty) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) mem[i] <= mem[i+1];
      depth <= depth - 1'b1;
    end
endmodule

// File: rtl/branch_unit.sv
// branch_unit: three-phase PC sequencer with flag-mask branches and call/return stack
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int FLAG_W = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               rx_valid,
  output logic               tx_ready,
  input  logic [2:0]         rx_op,
  input  logic [PC_W-1:0]    rx_target,
  input  logic [FLAG_W-1:0]  rx_mask,
  input  logic [FLAG_W-1:0]  rx_flags,
  output logic [PC_W-1:0]    tx_pc,
  output logic               tx_pc_valid,
  output logic               tx_taken,
  output logic               tx_fault,
  output logic [DEPTH_W-1:0] tx_depth
);
  state_t state;
  op_t op;
  logic [PC_W-1:0] target, pc_inc, top;
  logic [FLAG_W-1:0] mask, flags;
  logic taken_r, fault_r, full, empty, push, pop;
  assign pc_inc = tx_pc + 1'b1;
  assign push = state == COMMIT && op == OP_CALL && taken_r;
  assign pop = state == COMMIT && op == OP_RET && taken_r;
  branch_stack #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .aclk(aclk), .aresetn(aresetn), .push(push), .pop(pop), .push_data(pc_inc),
    .top(top), .full(full), .empty(empty), .depth(tx_depth)
  );
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      op <= OP_NEXT;
      target <= '0;
      mask <= '0;
      flags <= '0;
      taken_r <= 1'b0;
      fault_r <= 1'b0;
      tx_pc <= RESET_PC;
      tx_ready <= 1'b1;
      tx_pc_valid <= 1'b0;
      tx_taken <= 1'b0;
      tx_fault <= 1'b0;
    end else begin
      tx_pc_valid <= 1'b0;
      tx_taken <= 1'b0;
      tx_fault <= 1'b0;
      case (state)
        IDLE: if (rx_valid) begin
          op <= op_t'(rx_op);
          target <= rx_target;
          mask <= rx_mask;
          flags <= rx_flags;
          tx_ready <= 1'b0;
          state <= EVAL;
        end
        EVAL: begin
          // A blocked CALL/RET is reported as not taken so COMMIT falls through to pc+1.
          taken_r <= op == OP_CALL ? !full : op == OP_RET ? !empty :
                     cond_eval(op, COND_W'(flags), COND_W'(mask));
          fault_r <= (op == OP_CALL && full) || (op == OP_RET && empty);
          state <= COMMIT;
        end
        COMMIT: begin
          tx_pc <= !taken_r ? pc_inc : op == OP_RET ? top : target;
          tx_pc_valid <= 1'b1;
          tx_taken <= taken_r;
          tx_fault <= fault_r;
          tx_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed and randomized checks of branch_unit against a queue-based model
module tb_branch_unit;
  logic aclk = 0, aresetn = 0, rx_valid = 0, tx_ready, tx_pc_valid, tx_taken, tx_fault;
  logic [2:0] rx_op = 0, tx_depth;
  logic [15:0] rx_target = 0, tx_pc;
  logic [7:0] rx_mask = 0, rx_flags = 0;
  int checks = 0, failures = 0;
  logic [15:0] m_pc = 0;
  logic [15:0] m_stk[$];

  branch_unit dut (
    .aclk(aclk), .aresetn(aresetn), .rx_valid(rx_valid), .tx_ready(tx_ready), .rx_op(rx_op),
    .rx_target(rx_target), .rx_mask(rx_mask), .rx_flags(rx_flags), .tx_pc(tx_pc),
    .tx_pc_valid(tx_pc_valid), .tx_taken(tx_taken), .tx_fault(tx_fault), .tx_depth(tx_depth)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic model(input logic [2:0] op, input logic [15:0] tgt, input logic [7:0] msk, flg,
                       output logic [15:0] ep, output logic et, ef, output logic [2:0] ed);
    logic [7:0] hit;
    logic [15:0] nxt, ret;
    hit = flg & msk;
    nxt = m_pc + 16'd1;
    ret = 0;
    et = 0;
    ef = 0;
    case (op)
      1: et = 1;
      2: et = hit != 0;
      3: et = hit == msk;
      4: et = hit == 0;
      5: if (m_stk.size() == 4) ef = 1; else begin m_stk.push_back(nxt); et = 1; end
      6: if (m_stk.size() == 0) ef = 1; else begin ret = m_stk.pop_back(); et = 1; end
      default: et = 0;
    endcase
    ep = !et ? nxt : op == 6 ? ret : tgt;
    m_pc = ep;
    ed = 3'(m_stk.size());
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] tgt, input logic [7:0] msk, flg,
                       output logic [15:0] gp, output logic gt, gf, output logic [2:0] gd,
                       output int lat, output logic rok);
    int n;
    n = 0;
    while (!tx_ready && n < 8) begin @(negedge aclk); n++; end
    rx_valid = 1; rx_op = op; rx_target = tgt; rx_mask = msk; rx_flags = flg;
    @(posedge aclk); #1;
    rx_valid = 0; rx_op = 3'($urandom); rx_target = 16'($urandom);
    rx_mask = 8'($urandom); rx_flags = 8'($urandom);
    rok = !tx_ready && !tx_pc_valid;
    lat = 0;
    do begin
      @(posedge aclk); #1;
      lat++;
      if (lat == 1) rok &= !tx_ready && !tx_pc_valid;
    end while (!tx_pc_valid && lat < 6);
    rok &= tx_ready;
    gp = tx_pc; gt = tx_taken; gf = tx_fault; gd = tx_depth;
    @(posedge aclk); #1;
    rok &= !tx_pc_valid && !tx_taken && !tx_fault && tx_pc === gp;
  endtask

  task automatic test_reset();
    @(negedge aclk); aresetn = 0; #1;
    m_pc = 0; m_stk.delete();
    checks++;
    if ({tx_pc, tx_ready, tx_pc_valid, tx_taken, tx_fault, tx_depth} !== {16'h0, 4'b1000, 3'd0}) begin
      failures++;
      $display("FAIL reset pc=%h ready=%b valid=%b taken=%b fault=%b depth=%0d exp 0000/1/0/0/0/0",
               tx_pc, tx_ready, tx_pc_valid, tx_taken, tx_fault, tx_depth);
    end
    @(negedge aclk); aresetn = 1;
  endtask

  task automatic test_next();
    logic [15:0] ep, gp; logic et, ef, gt, gf, rok; logic [2:0] ed, gd; int lat;
    for (int i = 0; i < 3; i++) begin
      model(0, 16'($urandom), 8'($urandom), 8'($urandom), ep, et, ef, ed);
      issue(0, 16'($urandom), 8'($urandom), 8'($urandom), gp, gt, gf, gd, lat, rok);
      checks++;
      if ({gp, gt, gf, gd} !== {ep, et, ef, ed} || gp !== 16'(i + 1)) begin
        failures++;
        $display("FAIL next[%0d] pc/taken/fault/depth got %h/%b/%b/%0d exp %h/%b/%b/%0d", i, gp, gt, gf, gd, ep, et, ef, ed);
      end
      checks++;
      if (lat != 2 || rok !== 1'b1) begin
        failures++;
        $display("FAIL next_timing[%0d] latency=%0d ready/pulse_ok=%b exp 2/1", i, lat, rok);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] ops[8] = '{2, 2, 3, 3, 4, 2, 3, 4};
    logic [7:0] msks[8] = '{8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h0C};
    logic [7:0] flgs[8] = '{8'h04, 8'h03, 8'h0C, 8'h08, 8'hFF, 8'hFF, 8'h00, 8'h04};
    logic [15:0] ep, gp, tgt; logic et, ef, gt, gf, rok; logic [2:0] ed, gd; int lat;
    for (int i = 0; i < 8; i++) begin
      tgt = 16'h0100 * 16'(i + 1);
      model(ops[i], tgt, msks[i], flgs[i], ep, et, ef, ed);
      issue(ops[i], tgt, msks[i], flgs[i], gp, gt, gf, gd, lat, rok);
      checks++;
      if ({gp, gt, gf, gd} !== {ep, et, ef, ed}) begin
        failures++;
        $display("FAIL branch[%0d] op=%0d pc/taken/fault/depth got %h/%b/%b/%0d exp %h/%b/%b/%0d", i, ops[i], gp, gt, gf, gd, ep, et, ef, ed);
      end
      checks++;
      if (lat != 2 || rok !== 1'b1) begin
        failures++;
        $display("FAIL branch_timing[%0d] latency=%0d ready/pulse_ok=%b exp 2/1", i, lat, rok);
      end
    end
  endtask

  task automatic test_call_ret();
    logic [2:0] ops[4] = '{1, 0, 5, 6};
    logic [15:0] tgts[4] = '{16'hFFFF, 16'h1111, 16'h0040, 16'h2222};
    logic [15:0] exps[4] = '{16'hFFFF, 16'h0000, 16'h0040, 16'h0001};
    logic [15:0] ep, gp; logic et, ef, gt, gf, rok; logic [2:0] ed, gd; int lat;
    for (int i = 0; i < 4; i++) begin
      model(ops[i], tgts[i], 8'h00, 8'h00, ep, et, ef, ed);
      issue(ops[i], tgts[i], 8'h00, 8'h00, gp, gt, gf, gd, lat, rok);
      checks++;
      if ({gp, gt, gf, gd} !== {ep, et, ef, ed} || gp !== exps[i]) begin
        failures++;
        $display("FAIL call_ret[%0d] pc/taken/fault/depth got %h/%b/%b/%0d exp %h/%b/%b/%0d", i, gp, gt, gf, gd, exps[i], et, ef, ed);
      end
      checks++;
      if (lat != 2 || rok !== 1'b1) begin
        failures++;
        $display("FAIL call_ret_timing[%0d] latency=%0d ready/pulse_ok=%b exp 2/1", i, lat, rok);
      end
    end
  endtask

  task automatic test_stack_fault();
    logic [2:0] op;
    logic [15:0] ep, gp; logic et, ef, gt, gf, rok; logic [2:0] ed, gd; int lat;
    for (int i = 0; i < 10; i++) begin
      op = i < 5 ? 3'd5 : 3'd6;
      model(op, 16'h1000 + 16'(i), 8'h00, 8'h00, ep, et, ef, ed);
      issue(op, 16'h1000 + 16'(i), 8'h00, 8'h00, gp, gt, gf, gd, lat, rok);
      checks++;
      if ({gp, gt, gf, gd} !== {ep, et, ef, ed} || gf !== (i == 4 || i == 9)) begin
        failures++;
        $display("FAIL stack[%0d] op=%0d pc/taken/fault/depth got %h/%b/%b/%0d exp %h/%b/%b/%0d", i, op, gp, gt, gf, gd, ep, et, ef, ed);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ep, gp; logic et, ef, gt, gf, rok; logic [2:0] ed, gd; int lat;
    logic seen;
    model(5, 16'h0300, 8'h00, 8'h00, ep, et, ef, ed);
    issue(5, 16'h0300, 8'h00, 8'h00, gp, gt, gf, gd, lat, rok);
    @(negedge aclk); rx_valid = 1; rx_op = 1; rx_target = 16'h1234;
    @(posedge aclk); #1; rx_valid = 0;
    @(negedge aclk); aresetn = 0; #1;
    m_pc = 0; m_stk.delete();
    checks++;
    if ({tx_pc, tx_ready, tx_pc_valid, tx_taken, tx_fault, tx_depth} !== {16'h0, 4'b1000, 3'd0}) begin
      failures++;
      $display("FAIL reset_mid pc=%h ready=%b valid=%b taken=%b fault=%b depth=%0d exp 0000/1/0/0/0/0",
               tx_pc, tx_ready, tx_pc_valid, tx_taken, tx_fault, tx_depth);
    end
    @(negedge aclk); aresetn = 1; #1;
    seen = !tx_ready;
    repeat (4) begin @(posedge aclk); #1; if (tx_pc_valid || tx_pc !== 16'h0) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort pc=%h ready=%b stray_activity=%b exp 0000/1/0", tx_pc, tx_ready, seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] pat;
    logic [15:0] start;
    pat = 0;
    @(negedge aclk);
    start = m_pc;
    rx_valid = 1; rx_op = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge aclk); #1;
      pat[i] = tx_pc_valid;
      rx_op = i % 3 == 0 ? 3'd0 : 3'd1;
      rx_target = 16'($urandom);
    end
    rx_valid = 0;
    m_pc = start + 16'd4;
    checks++;
    if (pat !== 13'b1_0010_0100_1000 || tx_pc !== m_pc) begin
      failures++;
      $display("FAIL back_to_back pulses=%b pc=%h exp 1001001001000/%h", pat, tx_pc, m_pc);
    end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [15:0] tgt; logic [7:0] msk, flg;
    logic [15:0] ep, gp; logic et, ef, gt, gf, rok; logic [2:0] ed, gd; int lat;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      tgt = 16'($urandom);
      msk = 8'($urandom) & ($urandom_range(0, 1) ? 8'hFF : 8'h03);
      flg = 8'($urandom);
      model(op, tgt, msk, flg, ep, et, ef, ed);
      issue(op, tgt, msk, flg, gp, gt, gf, gd, lat, rok);
      checks++;
      if ({gp, gt, gf, gd} !== {ep, et, ef, ed} || lat != 2 || rok !== 1'b1) begin
        failures++;
        $display("FAIL random[%0d] op=%0d pc/taken/fault/depth/lat/ok got %h/%b/%b/%0d/%0d/%b exp %h/%b/%b/%0d/2/1",
                 i, op, gp, gt, gf, gd, lat, rok, ep, et, ef, ed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_next();
    test_branch();
    test_call_ret();
    test_stack_fault();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
